imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader sitting directly upstream of the pipelined CPU.
- Accepts a stream of 32-bit instruction words over a valid/ready interface and writes them sequentially into instruction memory through the CPU's external port (addr_ext / wen_ext / wdata_ext).
- Once the last word is written, it holds the CPU enable high so execution starts from PC 0.
- It owns the only writer of the external instruction-memory port while loading.

Parameters:
- DATA_W, 32, instruction word width
- ADDR_W, 32, width of addr_ext
- DEPTH, 512, maximum number of words accepted in one load
- BASE_ADDR, 0, address of the first word written
- STRIDE, 4, address increment per word (byte addressing)

Ports:
- clk  input  1  main clock
- arst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE
- clear  input  1  synchronous return to IDLE from any state; drops cpu_enable
- in_valid  input  1  source presents a word
- in_ready  output  1  loader accepts a word this cycle
- in_data  input  DATA_W  instruction word
- in_last  input  1  marks the final word of the program
- addr_ext  output  ADDR_W  instruction-memory external address
- wen_ext  output  1  instruction-memory external write enable
- ren_ext  output  1  instruction-memory external read enable; tied 0
- wdata_ext  output  DATA_W  instruction-memory external write data
- cpu_enable  output  1  drives the CPU enable input
- word_count  output  $clog2(DEPTH+1)  words written in the current or last load
- busy  output  1  high in LOAD
- error  output  1  overflow flag, sticky until clear or start

Behaviour:
- Reset value of every output is 0, except addr_ext = BASE_ADDR. The FSM resets to IDLE.
- Handshake:
  - in_ready = (state == LOAD), combinational from state only; it does not depend on in_valid.
  - A transfer occurs when in_valid & in_ready.
- Write timing: on a transfer, the next cycle registers
  - addr_ext = BASE_ADDR + idx*STRIDE
  - wdata_ext = in_data
  - wen_ext = 1 for exactly one cycle
  - idx then increments. Latency from transfer to write is 1 cycle, and back-to-back transfers give back-to-back writes.
- FSM states and transitions:
  - IDLE: start -> LOAD. idx and word_count go to 0, error goes to 0.
  - LOAD, transfer with in_last -> DONE.
  - LOAD, transfer without in_last while idx == DEPTH-1 -> ERR. That word is still written.
  - LOAD, no transfer: stay.
  - DONE: cpu_enable rises 1 cycle after entering DONE, so it is never asserted in the same cycle as the final wen_ext. It stays high until clear.
  - ERR: error = 1, cpu_enable = 0, stay until clear.
  - Any state, clear: -> IDLE. cpu_enable = 0. A pending write registered in the previous cycle still completes.
- Simultaneous events: clear has priority over start and over a transfer.
- start outside IDLE is ignored.
- in_last on the DEPTH-th word -> DONE, not ERR.
- word_count saturates at DEPTH and holds after DONE or ERR.
- Address arithmetic is ADDR_W wide and modulo 2^ADDR_W; there is no wrap check.
- Asynchronous reset mid-load aborts immediately: wen_ext = 0, and memory contents are left as written.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN
- Defined:
  - Adds output checksum [DATA_W-1:0], a running 32-bit wrapping sum of accepted words.
  - Cleared on start or clear.
  - Adds input exp_checksum [DATA_W-1:0], sampled on entry to DONE.
  - On mismatch the FSM goes to ERR instead of DONE, and cpu_enable stays 0.
- Not defined: neither port exists, and DONE is entered unconditionally on the last word.

Decomposition:
- Shared package imem_loader_pkg:
  - state enum: IDLE, LOAD, DONE, ERR
  - default DEPTH, STRIDE and BASE_ADDR constants
- One sub-module is natural: imem_loader_wr_stage, the registered addr/data/wen output stage fed by a transfer strobe and idx.
- Counter and FSM stay in the top.

Test Plan:
- Program write: start, then 3 words 0x20080005, 0x20090007, 0x01095020 with in_last on the third, in_valid held high -> wen_ext pulses on 3 consecutive cycles at addr 0x0, 0x4, 0x8 with matching data; cpu_enable = 1 two cycles after the third transfer; word_count = 3.
- Source stall: in_valid toggles 1,0,0,1 with 2 words -> exactly 2 writes at 0x0 and 0x4 with no gaps filled; busy high throughout LOAD.
- Overflow: DEPTH = 4, 4 words with no in_last -> 4 writes, error = 1, cpu_enable = 0. The same run with in_last on word 4 -> DONE, error = 0.
- Clear during a load after 2 transfers -> state IDLE, in_ready = 0, cpu_enable = 0; a new start then writes again from address 0x0.
- Asynchronous reset during a load, with arst_n low asynchronously mid-cycle -> wen_ext, cpu_enable and busy go to 0 immediately; addr_ext = BASE_ADDR.
- With IMEM_LOADER_CHECKSUM_EN: words 1, 2, 3 with exp_checksum = 6 -> DONE and cpu_enable = 1; with exp_checksum = 7 -> ERR and error = 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_loader_pkg : shared states and default geometry for the program loader
// Revision 1.0
// ----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam int          c_DEFAULT_DEPTH     = 512;
    localparam int          c_DEFAULT_STRIDE    = 4;
    localparam logic [31:0] c_DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/imem_loader_wr_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_loader_wr_stage : registered address/data/write-enable stage that
// drives the instruction-memory external port one cycle after a transfer
// Revision 1.0
// ----------------------------------------------------------------------------
module imem_loader_wr_stage #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                CNT_W     = 10,
    parameter int                STRIDE    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              xfer,
    input  logic [CNT_W-1:0]  idx,
    input  logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr_ext,
    output logic              wen_ext,
    output logic [DATA_W-1:0] wdata_ext
);

    logic [ADDR_W-1:0] w_addr;

    // Modulo 2^ADDR_W on purpose: no wrap detection on the address.
    assign w_addr = BASE_ADDR + ADDR_W'(idx) * ADDR_W'(STRIDE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            addr_ext  <= BASE_ADDR;
            wen_ext   <= 1'b0;
            wdata_ext <= '0;
        end else begin
            wen_ext <= xfer;
            if (xfer) begin
                addr_ext  <= w_addr;
                wdata_ext <= data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_loader : boot-time loader streaming words into instruction memory, then
// enabling the CPU. Optional running checksum via IMEM_LOADER_CHECKSUM_EN.
// Revision 1.0
// ----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = c_DEFAULT_DEPTH,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(c_DEFAULT_BASE_ADDR),
    parameter int                STRIDE    = c_DEFAULT_STRIDE
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       start,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_last,
    output logic [ADDR_W-1:0]          addr_ext,
    output logic                       wen_ext,
    output logic                       ren_ext,
    output logic [DATA_W-1:0]          wdata_ext,
    output logic                       cpu_enable,
    output logic [$clog2(DEPTH+1)-1:0] word_count,
    output logic                       busy,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0]          checksum,
    input  logic [DATA_W-1:0]          exp_checksum,
`endif
    output logic                       error
);

    localparam int CNT_W = $clog2(DEPTH+1);

    state_t           r_state;
    logic [CNT_W-1:0] r_idx;
    logic             w_xfer;
    logic             w_last_ok;

    assign in_ready   = (r_state == LOAD);
    assign w_xfer     = in_valid && in_ready && !clear;
    assign ren_ext    = 1'b0;
    assign word_count = r_idx;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    logic [DATA_W-1:0] w_sum_next;

    assign w_sum_next = r_sum + in_data;
    assign w_last_ok  = (w_sum_next == exp_checksum);
    assign checksum   = r_sum;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            r_sum <= '0;
        else if (clear || (r_state == IDLE && start))
            r_sum <= '0;
        else if (w_xfer)
            r_sum <= w_sum_next;
    end
`else
    assign w_last_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            busy       <= 1'b0;
            cpu_enable <= 1'b0;
            error      <= 1'b0;
        end else if (clear) begin
            r_state    <= IDLE;
            busy       <= 1'b0;
            cpu_enable <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        error   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_xfer) begin
                        if (r_idx != CNT_W'(DEPTH))
                            r_idx <= r_idx + CNT_W'(1);
                        // in_last wins over overflow, so the DEPTH-th word may end cleanly.
                        if (in_last && w_last_ok) begin
                            r_state <= DONE;
                            busy    <= 1'b0;
                        end else if (in_last || r_idx == CNT_W'(DEPTH-1)) begin
                            r_state <= ERR;
                            busy    <= 1'b0;
                            error   <= 1'b1;
                        end
                    end
                end
                // One-cycle gap keeps cpu_enable clear of the final write.
                DONE: cpu_enable <= 1'b1;
                ERR: begin
                    cpu_enable <= 1'b0;
                    error      <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    imem_loader_wr_stage #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .STRIDE    (STRIDE),
        .BASE_ADDR (BASE_ADDR)
    ) u_wr_stage (
        .clk       (clk),
        .arst_n    (arst_n),
        .xfer      (w_xfer),
        .idx       (r_idx),
        .data      (in_data),
        .addr_ext  (addr_ext),
        .wen_ext   (wen_ext),
        .wdata_ext (wdata_ext)
    );

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_imem_loader : directed and randomized program loads against a
// queue-based model of the expected memory writes and final status
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          arst_n;
    logic          start;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic [31:0]   addr_ext;
    logic          wen_ext;
    logic          ren_ext;
    logic [31:0]   wdata_ext;
    logic          cpu_enable;
    logic [CW-1:0] word_count;
    logic          busy;
    logic          error;
    logic [31:0]   checksum;
    logic [31:0]   exp_sum;

    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    logic [31:0] prog [16];
    logic [63:0] wr_q [$];
    int unsigned wr_cyc [$];
    int unsigned xc_q [$];

    imem_loader #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .DEPTH     (DEPTH),
        .BASE_ADDR (32'h0),
        .STRIDE    (4)
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .start        (start),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .addr_ext     (addr_ext),
        .wen_ext      (wen_ext),
        .ren_ext      (ren_ext),
        .wdata_ext    (wdata_ext),
        .cpu_enable   (cpu_enable),
        .word_count   (word_count),
        .busy         (busy),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .checksum     (checksum),
        .exp_checksum (exp_sum),
`endif
        .error        (error)
    );

`ifndef IMEM_LOADER_CHECKSUM_EN
    assign checksum = 32'h0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory-port monitor: every write seen on the external port
    always @(negedge clk) begin
        if (wen_ext === 1'b1) begin
            wr_q.push_back({addr_ext, wdata_ext});
            wr_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_clear(input string tag);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk({tag, "_clr_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_clr_cpu"},   64'(cpu_enable), 64'd0);
        chk({tag, "_clr_busy"},  64'(busy), 64'd0);
        chk({tag, "_clr_err"},   64'(error), 64'd0);
    endtask

    // mode 0: in_valid always high, 1: follow pat, 2: random in_valid
    task automatic run_load(input string tag, input int n, input int lastpos, input int mode,
                            input logic [7:0] pat, input bit bad_sum);
        int          acc = 0;
        bit          is_last = 0;
        bit          ok;
        bit          fin;
        bit          exp_done;
        bit          exp_err;
        logic [31:0] sum = 32'h0;
        int          sent = 0;
        int          budget = 0;
        bit          v;
        logic [63:0] e;

        for (int i = 0; i < n; i++) begin
            if (acc == DEPTH) break;
            acc++;
            sum = sum + prog[i];
            if (i == lastpos) begin
                is_last = 1'b1;
                break;
            end
        end
        exp_sum = bad_sum ? sum + 32'd1 : sum;
`ifdef IMEM_LOADER_CHECKSUM_EN
        ok = !is_last || (sum == exp_sum);
`else
        ok = 1'b1;
`endif
        fin      = is_last || (acc == DEPTH);
        exp_done = is_last && ok;
        exp_err  = fin && !exp_done;

        wr_q.delete();
        wr_cyc.delete();
        xc_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_start_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_start_wc"},    64'(word_count), 64'd0);
        chk({tag, "_start_err"},   64'(error), 64'd0);

        while (sent < acc && budget < 100) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = pat[budget % 8];
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = prog[sent];
            in_last  = (sent == lastpos);
            chk({tag, "_busy"},  64'(busy), 64'd1);
            chk({tag, "_ready"}, 64'(in_ready), 64'd1);
            if (v) begin
                xc_q.push_back(cyc);
                sent++;
            end
            budget++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
        if (budget >= 100) chk({tag, "_timeout"}, 64'(sent), 64'(acc));

        chk({tag, "_last_wen"},  64'(wen_ext), 64'd1);
        chk({tag, "_last_cpu"},  64'(cpu_enable), 64'd0);
        chk({tag, "_last_busy"}, 64'(busy), 64'(!fin));
        chk({tag, "_last_err"},  64'(error), 64'(exp_err));
        @(negedge clk);
        chk({tag, "_cpu_en"},    64'(cpu_enable), 64'(exp_done));
        chk({tag, "_end_ready"}, 64'(in_ready), 64'(!fin));
        chk({tag, "_end_err"},   64'(error), 64'(exp_err));
        chk({tag, "_wc"},        64'(word_count), 64'(acc));
        chk({tag, "_ren"},       64'(ren_ext), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk({tag, "_csum"},      64'(checksum), 64'(sum));
`endif
        @(negedge clk);
        chk({tag, "_nwrites"}, 64'(wr_q.size()), 64'(acc));
        for (int i = 0; i < acc && i < wr_q.size(); i++) begin
            e = wr_q[i];
            chk({tag, "_addr"}, {32'h0, e[63:32]}, 64'(i * 4));
            chk({tag, "_data"}, {32'h0, e[31:0]},  64'(prog[i]));
            chk({tag, "_wcyc"}, 64'(wr_cyc[i]),    64'(xc_q[i] + 1));
        end
    endtask

    initial begin
        arst_n   = 1'b0;
        start    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        in_last  = 1'b0;
        exp_sum  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_wen",   64'(wen_ext), 64'd0);
        chk("rst_cpu",   64'(cpu_enable), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_err",   64'(error), 64'd0);
        chk("rst_wc",    64'(word_count), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_addr",  64'(addr_ext), 64'd0);
        chk("rst_wdata", 64'(wdata_ext), 64'd0);
        chk("rst_ren",   64'(ren_ext), 64'd0);
        arst_n = 1'b1;
        @(negedge clk);

        prog[0] = 32'h20080005;
        prog[1] = 32'h20090007;
        prog[2] = 32'h01095020;
        run_load("prog", 3, 2, 0, 8'h00, 1'b0);

        // start outside IDLE must not disturb a finished load
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("ign_start_cpu",   64'(cpu_enable), 64'd1);
        chk("ign_start_ready", 64'(in_ready), 64'd0);
        do_clear("prog");

        prog[0] = 32'hCAFE0001;
        prog[1] = 32'hCAFE0002;
        run_load("stall", 2, 1, 1, 8'b1001_1001, 1'b0);
        do_clear("stall");

        for (int i = 0; i < 6; i++) prog[i] = 32'h1000_0000 + 32'(i);
        run_load("ovf", 4, -1, 0, 8'h00, 1'b0);
        do_clear("ovf");
        run_load("ovf_last", 4, 3, 0, 8'h00, 1'b0);
        do_clear("ovf_last");
        run_load("ovf_long", 6, -1, 2, 8'h00, 1'b0);
        do_clear("ovf_long");

        // Partial load, then clear colliding with a transfer
        run_load("part", 2, -1, 0, 8'h00, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_xfer_ready", 64'(in_ready), 64'd0);
        chk("clr_xfer_cpu",   64'(cpu_enable), 64'd0);
        chk("clr_xfer_busy",  64'(busy), 64'd0);
        @(negedge clk);
        chk("clr_xfer_nowr",  64'(wr_q.size()), 64'd2);
        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        chk("clr_start_ready", 64'(in_ready), 64'd0);
        run_load("reload", 3, 2, 2, 8'h00, 1'b0);
        do_clear("reload");

`ifdef IMEM_LOADER_CHECKSUM_EN
        prog[0] = 32'd1;
        prog[1] = 32'd2;
        prog[2] = 32'd3;
        run_load("csum_ok", 3, 2, 0, 8'h00, 1'b0);
        do_clear("csum_ok");
        run_load("csum_bad", 3, 2, 0, 8'h00, 1'b1);
        do_clear("csum_bad");
`endif

        for (int r = 0; r < 20; r++) begin
            int n;
            int lp;
            n  = int'($urandom_range(1, 6));
            lp = int'($urandom_range(0, 7));
            if (lp >= n) lp = -1;
            for (int i = 0; i < 8; i++) prog[i] = $urandom;
            run_load("rnd", n, lp, 2, 8'h00, 1'($urandom_range(0, 1)));
            do_clear("rnd");
        end

        // Asynchronous reset in the middle of a cycle while writing
        for (int i = 0; i < 4; i++) prog[i] = 32'hA5A5_0000 + 32'(i);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = prog[0];
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        in_data = prog[1];
        chk("arst_pre_wen",  64'(wen_ext), 64'd1);
        chk("arst_pre_busy", 64'(busy), 64'd1);
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_wen",   64'(wen_ext), 64'd0);
        chk("arst_cpu",   64'(cpu_enable), 64'd0);
        chk("arst_busy",  64'(busy), 64'd0);
        chk("arst_addr",  64'(addr_ext), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("arst_after_wc", 64'(word_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
